// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and its datapath.
//   op, funct, zero : instruction fields and ALU zero flag (datapath -> controller)
//   iord .. alucontrol, pcen : datapath control strobes/selects (controller -> datapath)
//   state           : current controller state, exported for debug
// Modports: master = datapath side, slave = controller side.
interface multicycle_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic       pcen;
  logic [2:0] alucontrol;
  logic [3:0] state;

  modport master (
    output op, funct, zero,
    input  iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, pcen, alucontrol, state
  );

  modport slave (
    input  op, funct, zero,
    output iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, pcen, alucontrol, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-subset controller: main FSM plus ALU decoder.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset, forces FETCH
//   bus   : multicycle_controller_if.slave (op/funct/zero in, control outputs and state out)
//
// state    | meaning
// ---------+--------------------------------------------
// FETCH    | load IR, PC <= PC + 4
// DECODE   | compute branch target, dispatch on op
// MEMADR   | ALUOut <= A + SignImm (lw/sw address)
// MEMREAD  | read memory at ALUOut
// MEMWB    | write loaded data to rt
// MEMWRITE | write B to memory at ALUOut
// EXECUTE  | R-type ALU operation
// ALUWB    | write ALUOut to rd
// BEQ      | compare A/B, branch when zero
// ADDIEXEC | A + SignImm
// ADDIWB   | write ALUOut to rt
// JUMP     | PC <= jump target
module multicycle_controller (
  input  logic                          clk,
  input  logic                          reset,
  multicycle_controller_if.slave        bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BEQ      = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t     state_q;
  state_t     state_d;

  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic       pcwrite;
  logic       branch;
  logic [1:0] aluop;
  logic [2:0] alucontrol;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Encodings 12-15 fall into the default arm: back to FETCH, outputs idle.
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:    state_d = DECODE;
      DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BEQ;
          OP_ADDI:      state_d = ADDIEXEC;
          OP_J:         state_d = JUMP;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR:   state_d = (bus.op == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD:  state_d = MEMWB;
      EXECUTE:  state_d = ALUWB;
      ADDIEXEC: state_d = ADDIWB;
      default:  state_d = FETCH;
    endcase
  end

  always_comb begin
    iord     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    aluop    = 2'b00;
    case (state_q)
      FETCH: begin
        irwrite = 1'b1;
        alusrcb = 2'b01;
        pcwrite = 1'b1;
      end
      DECODE:   alusrcb = 2'b11;
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMREAD:  iord = 1'b1;
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWRITE: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      EXECUTE: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      BEQ: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      ADDIEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      ADDIWB:   regwrite = 1'b1;
      JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    alucontrol = 3'b010;
    case (aluop)
      2'b01: alucontrol = 3'b110;
      2'b10: begin
        case (bus.funct)
          6'b100000: alucontrol = 3'b010;
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b010;
        endcase
      end
      default: alucontrol = 3'b010;
    endcase
  end

  // zero is used combinationally so a late-settling compare still gates pcen this cycle.
  assign bus.pcen       = pcwrite | (branch & bus.zero);
  assign bus.iord       = iord;
  assign bus.memwrite   = memwrite;
  assign bus.irwrite    = irwrite;
  assign bus.regdst     = regdst;
  assign bus.memtoreg   = memtoreg;
  assign bus.regwrite   = regwrite;
  assign bus.alusrca    = alusrca;
  assign bus.alusrcb    = alusrcb;
  assign bus.pcsrc      = pcsrc;
  assign bus.alucontrol = alucontrol;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller. Per-cycle expected control
// words are queued when an instruction is issued and popped as the DUT steps.
module tb_multicycle_controller;

  typedef struct packed {
    logic [3:0] state;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       pcen;
    logic [2:0] alucontrol;
  } ctrl_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  ctrl_t sb_q[$];

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ctrl_t observed();
    ctrl_t o;
    o.state      = bus.state;
    o.iord       = bus.iord;
    o.memwrite   = bus.memwrite;
    o.irwrite    = bus.irwrite;
    o.regdst     = bus.regdst;
    o.memtoreg   = bus.memtoreg;
    o.regwrite   = bus.regwrite;
    o.alusrca    = bus.alusrca;
    o.alusrcb    = bus.alusrcb;
    o.pcsrc      = bus.pcsrc;
    o.pcen       = bus.pcen;
    o.alucontrol = bus.alucontrol;
    return o;
  endfunction

  // Reference control word for one state, straight from the state/output table.
  function automatic ctrl_t expected(input logic [3:0] st, input logic [5:0] fn, input logic z);
    ctrl_t e;
    logic [1:0] aop;
    logic pw, br;
    e = '0; aop = 2'b00; pw = 1'b0; br = 1'b0;
    e.state = st;
    case (st)
      4'd0:  begin e.irwrite = 1; e.alusrcb = 2'b01; pw = 1; end
      4'd1:  e.alusrcb = 2'b11;
      4'd2:  begin e.alusrca = 1; e.alusrcb = 2'b10; end
      4'd3:  e.iord = 1;
      4'd4:  begin e.memtoreg = 1; e.regwrite = 1; end
      4'd5:  begin e.iord = 1; e.memwrite = 1; end
      4'd6:  begin e.alusrca = 1; aop = 2'b10; end
      4'd7:  begin e.regdst = 1; e.regwrite = 1; end
      4'd8:  begin e.alusrca = 1; aop = 2'b01; e.pcsrc = 2'b01; br = 1; end
      4'd9:  begin e.alusrca = 1; e.alusrcb = 2'b10; end
      4'd10: e.regwrite = 1;
      4'd11: begin e.pcsrc = 2'b10; pw = 1; end
      default: ;
    endcase
    e.alucontrol = 3'b010;
    if (aop == 2'b01) e.alucontrol = 3'b110;
    else if (aop == 2'b10) begin
      case (fn)
        6'b100010: e.alucontrol = 3'b110;
        6'b100100: e.alucontrol = 3'b000;
        6'b100101: e.alucontrol = 3'b001;
        6'b101010: e.alucontrol = 3'b111;
        default:   e.alucontrol = 3'b010;
      endcase
    end
    e.pcen = pw | (br & z);
    return e;
  endfunction

  // Entry: just after a negedge, DUT in FETCH. Exit: same condition, next FETCH.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int exp_cycles, input string name);
    logic [3:0] seq[$];
    ctrl_t e, o;
    int n;
    seq = '{4'd0, 4'd1};
    case (op)
      6'b100011: seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
      6'b101011: seq = '{4'd0, 4'd1, 4'd2, 4'd5};
      6'b000000: seq = '{4'd0, 4'd1, 4'd6, 4'd7};
      6'b000100: seq = '{4'd0, 4'd1, 4'd8};
      6'b001000: seq = '{4'd0, 4'd1, 4'd9, 4'd10};
      6'b000010: seq = '{4'd0, 4'd1, 4'd11};
      default: ;
    endcase
    foreach (seq[i]) sb_q.push_back(expected(seq[i], fn, z));
    n = 0;
    while (sb_q.size() > 0) begin
      if (n > 0) @(negedge clk);
      e = sb_q.pop_front();
      // op/funct only matter in DECODE/MEMADR/EXECUTE; scramble them elsewhere.
      if (e.state == 4'd1 || e.state == 4'd2 || e.state == 4'd6) begin
        bus.op = op; bus.funct = fn;
      end else begin
        bus.op = 6'($urandom_range(0, 63)); bus.funct = 6'($urandom_range(0, 63));
      end
      bus.zero = z;
      #1;
      o = observed();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, n, o, e);
      end
      n++;
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.state !== 4'd0 || n != exp_cycles) begin
      failures++;
      $display("FAIL %s return: state=%0d after %0d cycles, expected state=0 after %0d",
               name, bus.state, n, exp_cycles);
    end
  endtask

  task automatic test_reset();
    ctrl_t o, e;
    reset = 1'b1;
    bus.op = 6'b100011; bus.funct = 6'd0; bus.zero = 1'b0;
    #3;
    e = expected(4'd0, 6'd0, 1'b0);
    o = observed();
    checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected %h", o, e);
    end
    repeat (2) @(posedge clk);
    #1;
    o = observed();
    checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL reset_held: got %h expected %h", o, e);
    end
    @(negedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_lw();
    run_instr(6'b100011, 6'd0, 1'b0, 5, "lw");
  endtask

  task automatic test_sw();
    run_instr(6'b101011, 6'd0, 1'b1, 4, "sw");
  endtask

  task automatic test_rtype();
    logic [5:0] fns[6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111};
    foreach (fns[i]) run_instr(6'b000000, fns[i], 1'b0, 4, "rtype");
  endtask

  task automatic test_addi();
    run_instr(6'b001000, 6'd0, 1'b0, 4, "addi");
  endtask

  task automatic test_beq();
    run_instr(6'b000100, 6'd0, 1'b1, 3, "beq_taken");
    run_instr(6'b000100, 6'd0, 1'b0, 3, "beq_not_taken");
    // zero toggled within the BEQ cycle must reach pcen without an edge
    bus.op = 6'b000100; bus.zero = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (bus.state !== 4'd8 || bus.pcen !== 1'b0) begin
      failures++;
      $display("FAIL beq_mid_zero0: state=%0d pcen=%b expected state=8 pcen=0", bus.state, bus.pcen);
    end
    bus.zero = 1'b1;
    #1;
    checks++;
    if (bus.pcen !== 1'b1) begin
      failures++;
      $display("FAIL beq_mid_zero1: pcen=%b expected 1", bus.pcen);
    end
    bus.zero = 1'b0;
    #1;
    checks++;
    if (bus.pcen !== 1'b0) begin
      failures++;
      $display("FAIL beq_mid_zero_back: pcen=%b expected 0", bus.pcen);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.state !== 4'd0) begin
      failures++;
      $display("FAIL beq_mid_return: state=%0d expected 0", bus.state);
    end
  endtask

  task automatic test_jump();
    run_instr(6'b000010, 6'd0, 1'b0, 3, "jump");
  endtask

  task automatic test_unknown_op();
    run_instr(6'b111111, 6'd0, 1'b1, 2, "unknown_op");
  endtask

  task automatic test_async_reset();
    bus.op = 6'b101011; bus.zero = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (bus.state !== 4'd5 || bus.memwrite !== 1'b1) begin
      failures++;
      $display("FAIL areset_pre: state=%0d memwrite=%b expected state=5 memwrite=1",
               bus.state, bus.memwrite);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.state !== 4'd0 || bus.memwrite !== 1'b0 || bus.regwrite !== 1'b0 ||
        bus.pcen !== 1'b1 || bus.irwrite !== 1'b1) begin
      failures++;
      $display("FAIL areset_immediate: state=%0d memwrite=%b regwrite=%b pcen=%b irwrite=%b expected 0 0 0 1 1",
               bus.state, bus.memwrite, bus.regwrite, bus.pcen, bus.irwrite);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.state !== 4'd0) begin
      failures++;
      $display("FAIL areset_hold: state=%0d expected 0", bus.state);
    end
    @(negedge clk);
    #1 reset = 1'b0;
    run_instr(6'b101011, 6'd0, 1'b0, 4, "sw_after_reset");
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops[7] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b010101};
    int cyc[7] = '{5, 4, 4, 3, 4, 3, 2};
    logic [5:0] fns[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    for (int k = 0; k < 20; k++) begin
      int i;
      int f;
      i = $urandom_range(0, 6);
      f = $urandom_range(0, 4);
      run_instr(ops[i], fns[f], 1'($urandom_range(0, 1)), cyc[i], "back_to_back");
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_lw();
    test_sw();
    test_rtype();
    test_addi();
    test_beq();
    test_jump();
    test_unknown_op();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, expected completion before 200000");
    $fatal(1, "timeout");
  end

endmodule
